// File: rtl/conv_nm_if.sv
// Stream bundle for conv_nm: x and f sample inputs plus the y result output.
// slave is the convolver side, master is the source/consumer side.
`timescale 1ns/1ps
interface conv_nm_if #(
  parameter int T = 8,
  parameter int P = 18
) ();
  logic signed [T-1:0] s_data_in_x;
  logic                s_valid_x;
  logic                s_ready_x;
  logic signed [T-1:0] s_data_in_f;
  logic                s_valid_f;
  logic                s_ready_f;
  logic signed [P-1:0] m_data_out_y;
  logic                m_valid_y;
  logic                m_ready_y;

  modport slave (
    input  s_data_in_x, s_valid_x,
    output s_ready_x,
    input  s_data_in_f, s_valid_f,
    output s_ready_f,
    output m_data_out_y, m_valid_y,
    input  m_ready_y
  );

  modport master (
    output s_data_in_x, s_valid_x,
    input  s_ready_x,
    output s_data_in_f, s_valid_f,
    input  s_ready_f,
    input  m_data_out_y, m_valid_y,
    output m_ready_y
  );
endinterface

// File: rtl/conv_nm.sv
// Valid-mode 1-D convolution: loads N x samples and M taps, then emits N-M+1 results, one MAC per cycle.
// Optional macro CONV_RELU_EN clamps negative results to zero when the output register is loaded.
`timescale 1ns/1ps
module conv_nm #(
  parameter int N = 8,
  parameter int M = 4,
  parameter int T = 8,
  parameter int P = 2*T + $clog2(M)
) (
  input  logic      clk,
  input  logic      reset_n,
  conv_nm_if.slave  io
);
  localparam int XW = $clog2(N + 1);
  localparam int FW = $clog2(M + 1);
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = (M > 1) ? $clog2(M) : 1;
  localparam int MW = (N - M > 0) ? $clog2(N - M + 1) : 1;

  localparam logic [XW-1:0] X_FULL = XW'(N);
  localparam logic [FW-1:0] F_FULL = FW'(M);
  localparam logic [KW-1:0] J_LAST = KW'(M - 1);
  localparam logic [MW-1:0] M_LAST = MW'(N - M);

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_OUTPUT} state_t;

  state_t              state_q, state_d;
  logic [XW-1:0]       x_cnt_q, x_cnt_d;
  logic [FW-1:0]       f_cnt_q, f_cnt_d;
  logic [MW-1:0]       m_q, m_d;
  logic [KW-1:0]       j_q, j_d;
  logic signed [P-1:0] acc_q, acc_d;
  logic signed [P-1:0] y_q, y_d;

  logic signed [T-1:0] x_mem [N];
  logic signed [T-1:0] f_mem [M];

  logic                ready_x, ready_f, x_fire, f_fire;
  logic [AW-1:0]       x_idx;
  logic signed [2*T-1:0] prod;

  // Readiness depends only on registered state, so no input reaches an output combinationally.
  assign ready_x = (state_q == S_LOAD) && (x_cnt_q != X_FULL);
  assign ready_f = (state_q == S_LOAD) && (f_cnt_q != F_FULL);
  assign x_fire  = io.s_valid_x && ready_x;
  assign f_fire  = io.s_valid_f && ready_f;

  assign io.s_ready_x    = ready_x;
  assign io.s_ready_f    = ready_f;
  assign io.m_valid_y    = (state_q == S_OUTPUT);
  assign io.m_data_out_y = y_q;

  assign x_idx = AW'(m_q) + AW'(j_q);
  assign prod  = x_mem[x_idx] * f_mem[j_q];

  always_ff @(posedge clk) begin
    if (x_fire) x_mem[x_cnt_q[AW-1:0]] <= io.s_data_in_x;
    if (f_fire) f_mem[f_cnt_q[KW-1:0]] <= io.s_data_in_f;
  end

  always_comb begin
    state_d = state_q;
    x_cnt_d = x_cnt_q;
    f_cnt_d = f_cnt_q;
    m_d     = m_q;
    j_d     = j_q;
    acc_d   = acc_q;
    y_d     = y_q;
    unique case (state_q)
      S_LOAD: begin
        if (x_fire) x_cnt_d = x_cnt_q + 1'b1;
        if (f_fire) f_cnt_d = f_cnt_q + 1'b1;
        if (x_cnt_d == X_FULL && f_cnt_d == F_FULL) begin
          state_d = S_COMPUTE;
          m_d     = '0;
          j_d     = '0;
        end
      end
      S_COMPUTE: begin
        // P-bit cast sign-extends the product, or wraps it when P is overridden narrow.
        acc_d = ((j_q == '0) ? '0 : acc_q) + P'(prod);
        if (j_q == J_LAST) begin
          state_d = S_OUTPUT;
`ifdef CONV_RELU_EN
          y_d = acc_d[P-1] ? '0 : acc_d;
`else
          y_d = acc_d;
`endif
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      S_OUTPUT: begin
        if (io.m_ready_y) begin
          j_d = '0;
          if (m_q == M_LAST) begin
            x_cnt_d = '0;
            f_cnt_d = '0;
            m_d     = '0;
            state_d = S_LOAD;
          end else begin
            m_d     = m_q + 1'b1;
            state_d = S_COMPUTE;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_LOAD;
      x_cnt_q <= '0;
      f_cnt_q <= '0;
      m_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      x_cnt_q <= x_cnt_d;
      f_cnt_q <= f_cnt_d;
      m_q     <= m_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
    end
  end
endmodule

// File: doc/conv_nm.md
# conv_nm

Parametrised 1-D valid-mode convolution engine. It is the generalised successor of the fixed 8-input/4-tap convolver. It accepts an N-element signed input vector x and an M-tap signed filter f over two independent valid/ready streams. It produces N-M+1 signed results y[m] = Σ_{j=0..M-1} x[m+j]·f[j] on a valid/ready output stream, then returns to accept the next vector/filter pair. The block sits between the input stream sources and the result consumer in the convolution datapath.

## Interface
Parameters:
- N, 8, input vector length; must satisfy N ≥ M.
- M, 4, filter length; must satisfy M ≥ 1.
- T, 8, signed data width of x and f.
- P, 2*T+$clog2(M), signed output width. The default is lossless for any inputs.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- s_data_in_x  in  T  signed x sample.
- s_valid_x  in  1  x sample valid.
- s_ready_x  out  1  block can accept x.
- s_data_in_f  in  T  signed filter tap.
- s_valid_f  in  1  tap valid.
- s_ready_f  out  1  block can accept f.
- m_data_out_y  out  P  signed result.
- m_valid_y  out  1  result valid.
- m_ready_y  in  1  consumer accepts result.

## Operation
- Storage:
  - x memory: N×T.
  - f memory: M×T.
  - Counters: x_cnt [0..N], f_cnt [0..M], m (output index) [0..N-M], j (tap index) [0..M-1].
  - Accumulator: P bits.
- FSM states: LOAD → COMPUTE → OUTPUT.
- LOAD:
  - s_ready_x = (x_cnt < N); s_ready_f = (f_cnt < M).
  - A transfer occurs on valid & ready. The sample is written to mem[cnt] and cnt increments.
  - The two streams are independent; both may transfer in the same cycle.
  - Leave LOAD when x_cnt==N and f_cnt==M. This includes the cycle in which the final transfers occur.
- COMPUTE:
  - Both s_ready outputs are 0.
  - One MAC per cycle: acc ← (j==0 ? 0 : acc) + x[m+j]·f[j].
  - The T×T signed product is sign-extended to P bits.
  - After j==M-1, go to OUTPUT.
- OUTPUT:
  - m_valid_y=1 and m_data_out_y=acc, both held stable until m_ready_y=1.
  - On the handshake:
    - If m==N-M: clear x_cnt, f_cnt and m, then go to LOAD.
    - Otherwise: m++, j←0, go to COMPUTE.
- Inputs presented with valid=0 are ignored, including X data. Data is never sampled outside a handshake.
- If P is overridden below the lossless width, the result is truncated to the low P bits (two's-complement wrap).

## Timing
- Reset (asynchronous assert; deassert is synchronous to clk):
  - State=LOAD; all counters and acc = 0.
  - s_ready_x=1, s_ready_f=1, m_valid_y=0, m_data_out_y=0.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Latency:
  - The first COMPUTE cycle is the cycle after the last input transfer.
  - m_valid_y rises M cycles after entering COMPUTE.
  - Each further result appears M cycles after the previous output handshake.
- Throughput: one result per M+1 cycles when m_ready_y is held at 1.
- A stalled m_ready_y holds the result indefinitely with no loss.
- Reset asserted mid-COMPUTE or mid-OUTPUT discards the partial work. m_valid_y drops immediately (asynchronously).
- Extra input data offered while in COMPUTE/OUTPUT is not accepted (ready=0). The producer must hold it.

## Configuration
- CONV_RELU_EN:
  - Defined: m_data_out_y = (acc < 0) ? 0 : acc. The clamp is applied when loading the output register; the latency is unchanged.
  - Undefined: raw signed acc is output.

## Test plan
- Default parameters, first pair:
  - Stimulus: x={10,-20,30,-40,50,60,70,80}, f={10,20,-30,40}, ready always 1.
  - Response: y={-2800,3600,400,1600,2800}; with CONV_RELU_EN, y={0,3600,400,1600,2800}.
- Second pair, sent directly after the first:
  - Stimulus: x={-90,100,-110,120,-50,40,30,-20}, f={-50,-60,70,80}.
  - Response: y={400,6000,-2000,2200,600}; with CONV_RELU_EN, -2000 becomes 0.
- Randomized valid on x/f with invalid data driven to X, plus random m_ready_y on the first pair:
  - Identical results.
  - m_data_out_y is stable while valid & !ready.
  - m_valid_y is never asserted after the 5th handshake, checked for 100 cycles.
- Extremes (N=8, M=4): x all -128, f all -128 → five results of 65536, with no overflow at P=18.
- Reset mid-stream:
  - Stimulus: assert reset_n=0 during the 3rd COMPUTE, then reload the first pair.
  - Response: all outputs 0 at reset, followed by the correct {-2800,…,2800}.
- Parameter sweep:
  - N=M=1, x={-7}, f={5} → single y=-35.
  - N=16, M=1 → y equals x scaled by f[0].
